sram_req_master: RTL and testbench
==================================

// Module: sram_req_master
// PURPOSE
//  Initiator side of the single-port SRAM bus used by the DPI-C memory model.
//  Accepts one load/store request at a time from the LSU over valid/ready and
//  drives the mem_* port: en, addr, size, wmask, wdata.
//  Generates byte masks and store-data lane shifts; captures read data one cycle
//  after issue, then extracts and sign- or zero-extends it.
//  Returns the result over a valid/ready response channel.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  bus data width; only 32 is supported, so there are 4 byte lanes
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request valid
//  req_ready   out  1   request ready (high only in IDLE)
//  req_addr    in   32  byte address
//  req_wen     in   1   1 = store, 0 = load
//  req_size    in   2   0 = byte, 1 = half, 2 = word, 3 = illegal
//  req_signed  in   1   loads only: sign-extend when 1
//  req_wdata   in   32  store data, right-aligned
//  resp_valid  out  1   response valid
//  resp_ready  in   1   response ready
//  resp_rdata  out  32  load result after extension; 0 for stores and errors
//  resp_err    out  1   misaligned access or illegal size
//  mem_en      out  1   SRAM access strobe
//  mem_addr    out  32  byte address, passed through unmodified
//  mem_size    out  2   registered copy of req_size
//  mem_wmask   out  4   byte-lane write mask; all-zero means read
//  mem_wdata   out  32  lane-shifted store data
//  mem_rdata   in   32  aligned word containing mem_addr; valid the cycle after mem_en
// BEHAVIOUR
//  States and transitions:
//   - IDLE -> ISSUE on a good request.
//   - IDLE -> RESP on an erroring request.
//   - ISSUE -> CAPTURE for a load; ISSUE -> RESP for a store.
//   - CAPTURE -> RESP.
//   - RESP -> IDLE when resp_ready is high.
//  Reset: state = IDLE and every output = 0 except req_ready = 1.
//  Accept: req_valid & req_ready in cycle N registers every req_* field.
//  Error check, done at accept:
//   - size 3, or half with addr[0] = 1, or word with addr[1:0] != 0.
//   - On error: go to RESP in N+1 with resp_err = 1 and resp_rdata = 0.
//   - mem_en is never asserted for an erroring request.
//  mem_en: high for exactly one cycle, in ISSUE (N+1), and 0 in every other state.
//  mem_wmask: 0 unless mem_en is high and the request is a store.
//   - byte: 4'b0001 << addr[1:0]
//   - half: 4'b0011 << addr[1:0]
//   - word: 4'hF
//  mem_wdata: req_wdata << (8*addr[1:0]); lanes outside the mask are don't-care, driven 0.
//  Load path:
//   - CAPTURE (N+2) samples mem_rdata >> (8*addr[1:0]).
//   - Keep the low 8/16/32 bits, then sign- or zero-extend per req_signed.
//   - Write the result to a response register.
//  Response timing:
//   - store: resp_valid first high in N+2
//   - load: resp_valid first high in N+3
//   - error: resp_valid first high in N+1
//  Holding: resp_valid, resp_rdata and resp_err stay stable until resp_ready.
//  Response clears to 0 on the handshake; the next req_ready is in the following cycle.
//  Throughput: at most one outstanding request; req_ready is 0 in ISSUE, CAPTURE and RESP.
//  Reset mid-operation (any state): next cycle is IDLE with outputs at reset values.
//   - The pending response is dropped.
//   - A store already strobed in ISSUE is not undone.
//  mem_addr, mem_size and mem_wdata hold their last values outside ISSUE; mem_en qualifies them.
// TESTING
//  1. Store word: addr 0x80000004, data 0xDEADBEEF
//     -> N+1: mem_en = 1, wmask = 4'hF, wdata = 0xDEADBEEF.
//     -> N+2: resp_valid = 1, err = 0, rdata = 0.
//  2. Signed byte load: addr 0x80000003, mem_rdata = 0x80FF7F01
//     -> N+3: resp_rdata = 0xFFFFFF80.
//     Same with req_signed = 0 -> resp_rdata = 0x00000080.
//  3. Store half: addr 0x80000002, data 0x0000ABCD
//     -> mem_wmask = 4'b1100, mem_wdata = 0xABCD0000.
//  4. Word load at 0x80000001
//     -> mem_en never high; N+1: resp_valid = 1, resp_err = 1, resp_rdata = 0.
//     Repeat with size = 3 -> same response.
//  5. Unsigned half load: addr 0x80000002, mem_rdata = 0x8001FFFF
//     -> resp_rdata = 0x00008001.
//     Hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready = 0.
//  6. Assert rst in the ISSUE cycle of a load
//     -> next cycle: mem_en = 0, resp_valid = 0, req_ready = 1.
//     -> A new word read then completes normally.

Source files
------------

// File: rtl/sram_req_master.sv
// ----------------------------------------------------------------------------
// sram_req_master
// Initiator side of the single-port SRAM bus. Takes one load/store request at
// a time from the LSU over valid/ready, drives the mem_* strobe for one cycle,
// captures and extends load data, and returns the result over a valid/ready
// response channel.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_addr/wen/size/signed/wdata  request fields, registered at accept
//   resp_valid/resp_ready        response handshake
//   resp_rdata/resp_err          extended load data (0 for stores/errors), error flag
//   mem_en/addr/size/wmask/wdata SRAM request side, valid while mem_en is high
//   mem_rdata                    aligned read word, valid the cycle after mem_en
// ----------------------------------------------------------------------------
module sram_req_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_size,
    output logic [3:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Request fields kept for the load-extension step.
    logic [1:0]            r_off;
    logic                  r_wen;
    logic [1:0]            r_size;
    logic                  r_signed;

    // SRAM-side registers; only reloaded by a good request so they hold
    // their last issued values otherwise.
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [1:0]            r_mem_size;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mask;

    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;

    logic                  w_accept;
    logic                  w_err;
    logic [3:0]            w_mask_req;
    logic [DATA_WIDTH-1:0] w_lane_bits;
    logic [DATA_WIDTH-1:0] w_wdata_lanes;
    logic [DATA_WIDTH-1:0] w_rshift;
    logic [DATA_WIDTH-1:0] w_load_result;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            2'd1:    w_err = req_addr[0];
            2'd2:    w_err = (req_addr[1:0] != 2'b00);
            2'd3:    w_err = 1'b1;
            default: w_err = 1'b0;
        endcase
    end

    // Byte-lane mask for stores; loads carry an all-zero mask.
    always_comb begin
        w_mask_req = 4'h0;
        if (req_wen) begin
            case (req_size)
                2'd0:    w_mask_req = 4'b0001 << req_addr[1:0];
                2'd1:    w_mask_req = 4'b0011 << req_addr[1:0];
                default: w_mask_req = 4'hF;
            endcase
        end
    end

    // Expand the lane mask to bits so unused lanes of mem_wdata read as 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_bits[8*gi +: 8] = {8{w_mask_req[gi]}};
        end
    endgenerate

    assign w_wdata_lanes = (req_wdata << {req_addr[1:0], 3'b000}) & w_lane_bits;

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    assign w_rshift = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_result = w_rshift;
        case (r_size)
            2'd0:    w_load_result = {{24{r_signed & w_rshift[7]}},  w_rshift[7:0]};
            2'd1:    w_load_result = {{16{r_signed & w_rshift[15]}}, w_rshift[15:0]};
            default: w_load_result = w_rshift;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   w_state_next = r_wen ? S_RESP : S_CAPTURE;
            S_CAPTURE: w_state_next = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        mem_en     = (r_state == S_ISSUE);
        mem_wmask  = (r_state == S_ISSUE) ? r_mask : 4'h0;
        resp_valid = (r_state == S_RESP);
    end

    assign mem_addr   = r_mem_addr;
    assign mem_size   = r_mem_size;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_off        <= 2'b00;
            r_wen        <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_size   <= 2'b00;
            r_mem_wdata  <= '0;
            r_mask       <= 4'h0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_off        <= req_addr[1:0];
                r_wen        <= req_wen;
                r_size       <= req_size;
                r_signed     <= req_signed;
                r_resp_rdata <= '0;
                r_resp_err   <= w_err;
                if (!w_err) begin
                    r_mem_addr  <= req_addr;
                    r_mem_size  <= req_size;
                    r_mem_wdata <= w_wdata_lanes;
                    r_mask      <= w_mask_req;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_resp_rdata <= w_load_result;
            end
            // Response registers return to 0 once the LSU has taken them.
            if ((r_state == S_RESP) && resp_ready) begin
                r_resp_rdata <= '0;
                r_resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_master.sv
// ----------------------------------------------------------------------------
// tb_sram_req_master
// Directed bench for sram_req_master: stores, signed/unsigned loads, error
// responses, response back-pressure and reset in the middle of a load.
// ----------------------------------------------------------------------------
module tb_sram_req_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int en_count = 0;
    int en_snap;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en === 1'b1) en_count <= en_count + 1;
    end

    sram_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_size   (mem_size),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request for one accepted cycle (N); returns in cycle N+1.
    task automatic start_req(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                             input logic sgn, input logic [31:0] wdata);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_addr   = addr;
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        tick;
        req_valid  = 1'b0;
    endtask

    // Full load with resp_ready high: checks issue, capture and N+3 response.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
        mem_rdata = rdata;
        start_req(addr, 1'b0, size, sgn, 32'h0);
        check({tag, "_en_n1"}, {31'b0, mem_en}, 32'd1);
        check({tag, "_wmask_n1"}, {28'b0, mem_wmask}, 32'd0);
        check({tag, "_addr_n1"}, mem_addr, addr);
        check({tag, "_size_n1"}, {30'b0, mem_size}, {30'b0, size});
        tick;
        check({tag, "_en_n2"}, {31'b0, mem_en}, 32'd0);
        check({tag, "_rv_n2"}, {31'b0, resp_valid}, 32'd0);
        tick;
        check({tag, "_rv_n3"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_err_n3"}, {31'b0, resp_err}, 32'd0);
        check({tag, "_rdata_n3"}, resp_rdata, exp);
        $display("[TB] load %s addr=%h size=%0d signed=%0b rdata=%h result=%h",
                 tag, addr, size, sgn, rdata, resp_rdata);
        tick;
        check({tag, "_done_rv"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_wen    = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        mem_rdata  = 32'h0;
        tick;
        tick;
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_wmask", {28'b0, mem_wmask}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);

        // 1. Store word
        start_req(32'h8000_0004, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF);
        check("sw_en_n1", {31'b0, mem_en}, 32'd1);
        check("sw_wmask_n1", {28'b0, mem_wmask}, 32'h0000_000F);
        check("sw_wdata_n1", mem_wdata, 32'hDEAD_BEEF);
        check("sw_addr_n1", mem_addr, 32'h8000_0004);
        check("sw_rv_n1", {31'b0, resp_valid}, 32'd0);
        check("sw_ready_n1", {31'b0, req_ready}, 32'd0);
        tick;
        check("sw_en_n2", {31'b0, mem_en}, 32'd0);
        check("sw_wmask_n2", {28'b0, mem_wmask}, 32'd0);
        check("sw_rv_n2", {31'b0, resp_valid}, 32'd1);
        check("sw_err_n2", {31'b0, resp_err}, 32'd0);
        check("sw_rdata_n2", resp_rdata, 32'd0);
        $display("[TB] store word addr=80000004 data=deadbeef wmask=f");
        tick;
        check("sw_idle_ready", {31'b0, req_ready}, 32'd1);
        check("sw_hold_addr", mem_addr, 32'h8000_0004);

        // 2. Byte loads at lane 3, signed and unsigned
        do_load("lb", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_7F01, 32'hFFFF_FF80);
        do_load("lbu", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_7F01, 32'h0000_0080);

        // 3. Store half at lane 2
        start_req(32'h8000_0002, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD);
        check("sh_en_n1", {31'b0, mem_en}, 32'd1);
        check("sh_wmask_n1", {28'b0, mem_wmask}, 32'h0000_000C);
        check("sh_wdata_n1", mem_wdata, 32'hABCD_0000);
        tick;
        check("sh_rv_n2", {31'b0, resp_valid}, 32'd1);
        check("sh_rdata_n2", resp_rdata, 32'd0);
        $display("[TB] store half addr=80000002 data=abcd wmask=c");
        tick;

        // Store byte at lane 1
        start_req(32'h8000_0001, 1'b1, 2'd0, 1'b0, 32'h1234_5677);
        check("sb_wmask_n1", {28'b0, mem_wmask}, 32'h0000_0002);
        check("sb_wdata_n1", mem_wdata, 32'h0000_7700);
        $display("[TB] store byte addr=80000001 data=77 wmask=2");
        tick;
        tick;

        // 4. Misaligned word load, then illegal size
        en_snap = en_count;
        start_req(32'h8000_0001, 1'b0, 2'd2, 1'b0, 32'h0);
        check("err_mis_en_n1", {31'b0, mem_en}, 32'd0);
        check("err_mis_rv_n1", {31'b0, resp_valid}, 32'd1);
        check("err_mis_err_n1", {31'b0, resp_err}, 32'd1);
        check("err_mis_rdata_n1", resp_rdata, 32'd0);
        $display("[TB] load word addr=80000001 -> error response");
        tick;
        check("err_mis_cleared", {31'b0, resp_err}, 32'd0);
        start_req(32'h8000_0000, 1'b0, 2'd3, 1'b0, 32'h0);
        check("err_sz3_en_n1", {31'b0, mem_en}, 32'd0);
        check("err_sz3_rv_n1", {31'b0, resp_valid}, 32'd1);
        check("err_sz3_err_n1", {31'b0, resp_err}, 32'd1);
        check("err_sz3_rdata_n1", resp_rdata, 32'd0);
        $display("[TB] load size3 addr=80000000 -> error response");
        tick;
        check("err_no_strobe", en_count - en_snap, 32'd0);
        check("err_addr_held", mem_addr, 32'h8000_0001);

        // 5. Unsigned half load with response back-pressure
        resp_ready = 1'b0;
        mem_rdata  = 32'h8001_FFFF;
        start_req(32'h8000_0002, 1'b0, 2'd1, 1'b0, 32'h0);
        tick;
        tick;
        check("lhu_rv_n3", {31'b0, resp_valid}, 32'd1);
        check("lhu_rdata_n3", resp_rdata, 32'h0000_8001);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("lhu_hold_rv", {31'b0, resp_valid}, 32'd1);
            check("lhu_hold_rdata", resp_rdata, 32'h0000_8001);
            check("lhu_hold_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        tick;
        check("lhu_after_rv", {31'b0, resp_valid}, 32'd0);
        check("lhu_after_rdata", resp_rdata, 32'd0);
        check("lhu_after_ready", {31'b0, req_ready}, 32'd1);
        $display("[TB] load half addr=80000002 rdata=8001ffff result=00008001 (held 5 cycles)");

        // 6. Reset during ISSUE of a load, then a normal word read
        mem_rdata = 32'hCAFE_F00D;
        start_req(32'h8000_0000, 1'b0, 2'd2, 1'b0, 32'h0);
        check("rst_mid_en_issue", {31'b0, mem_en}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_mid_en", {31'b0, mem_en}, 32'd0);
        check("rst_mid_rv", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        $display("[TB] reset in ISSUE of load addr=80000000 -> dropped");
        tick;
        check("rst_mid_rv_later", {31'b0, resp_valid}, 32'd0);
        do_load("lw", 32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
